// File: rtl/demux_store.sv
// Write-addressed 32-slot register store with per-slot valid bits and a fill count.
// Defining DEMUX_CLEAR_EN adds the clr port and a 32-cycle sequential clear-all walk.
module demux_store #(
    parameter int DATA_SIZE = 32,
    parameter int SIZE      = DATA_SIZE * 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [4:0]           wr_sel,
    input  logic [DATA_SIZE-1:0] wr_data,
`ifdef DEMUX_CLEAR_EN
    input  logic                 clr,
`endif
    output logic [SIZE-1:0]      d_o,
    output logic [31:0]          slot_valid,
    output logic [5:0]           count,
    output logic                 full
);

    logic       write_fire;
    logic [5:0] count_next;

`ifdef DEMUX_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] clr_idx;

    assign wr_ready = (state == IDLE);
`else
    assign wr_ready = 1'b1;
`endif

    assign write_fire = wr_valid && wr_ready;

    // A write and a clear step never coincide: writes are only accepted in IDLE.
    always_comb begin
        count_next = count;
        if (write_fire && !slot_valid[wr_sel]) begin
            count_next = count + 6'd1;
        end
`ifdef DEMUX_CLEAR_EN
        if (state == CLEAR && slot_valid[clr_idx]) begin
            count_next = count - 6'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_o        <= '0;
            slot_valid <= '0;
            count      <= '0;
            full       <= 1'b0;
`ifdef DEMUX_CLEAR_EN
            state      <= IDLE;
            clr_idx    <= '0;
`endif
        end else begin
            if (write_fire) begin
                d_o[int'(wr_sel)*DATA_SIZE +: DATA_SIZE] <= wr_data;
                slot_valid[wr_sel]                       <= 1'b1;
            end
`ifdef DEMUX_CLEAR_EN
            // clr is only looked at in IDLE, so a clear in progress is never restarted.
            case (state)
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    d_o[int'(clr_idx)*DATA_SIZE +: DATA_SIZE] <= '0;
                    slot_valid[clr_idx]                       <= 1'b0;
                    clr_idx                                   <= clr_idx + 5'd1;
                    if (clr_idx == 5'd31) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
            count <= count_next;
            full  <= (count_next == 6'd32);
        end
    end

endmodule

// File: tb/tb_demux_store.sv
// Scoreboard bench for demux_store: writes push expected slot state, checks pop it after the edge.
// Clear-path scenarios are built only when DEMUX_CLEAR_EN is defined.
module tb_demux_store;

    localparam int DW = 32;
    localparam int SW = DW * 32;

    typedef struct {
        logic [4:0]    sel;
        logic [DW-1:0] data;
        logic [31:0]   valid;
        logic [5:0]    cnt;
        logic          full;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [4:0]    wr_sel = '0;
    logic [DW-1:0] wr_data = '0;
`ifdef DEMUX_CLEAR_EN
    logic          clr = 1'b0;
`endif
    logic [SW-1:0] d_o;
    logic [31:0]   slot_valid;
    logic [5:0]    count;
    logic          full;

    logic [DW-1:0] model_data [32];
    logic [31:0]   model_valid;
    exp_t          sb [$];
    int            vectors = 0;
    int            miscompares = 0;

    demux_store #(.DATA_SIZE(DW), .SIZE(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
`ifdef DEMUX_CLEAR_EN
        .clr        (clr),
`endif
        .d_o        (d_o),
        .slot_valid (slot_valid),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] model_bus();
        logic [SW-1:0] bus;
        bus = '0;
        for (int k = 0; k < 32; k++) bus[k*DW +: DW] = model_data[k];
        return bus;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 32; k++) model_data[k] = '0;
        model_valid = '0;
    endtask

    // Drives one write for one edge and records what the store should show afterwards.
    task automatic drive_write(input logic [4:0] sel, input logic [DW-1:0] data);
        exp_t e;
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = data;
        model_data[sel]  = data;
        model_valid[sel] = 1'b1;
        e.sel   = sel;
        e.data  = data;
        e.valid = model_valid;
        e.cnt   = 6'($countones(model_valid));
        e.full  = (e.cnt == 6'd32);
        sb.push_back(e);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (d_o !== '0 || slot_valid !== 32'h0 || count !== 6'd0 || full !== 1'b0 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset: slot_valid=%h count=%0d full=%b wr_ready=%b d_o_nonzero=%b, required 0/0/0/1/0",
                     slot_valid, count, full, wr_ready, d_o !== '0);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        drive_write(5'd5, 32'hDEADBEEF);
        e = sb.pop_front();
        vectors++;
        if (d_o[191:160] !== 32'hDEADBEEF || d_o[191:160] !== e.data) begin
            miscompares++;
            $display("[TB] FAIL single_data: got %h, required %h", d_o[191:160], e.data);
        end
        vectors++;
        if (slot_valid !== 32'h20 || count !== 6'd1 || count !== e.cnt) begin
            miscompares++;
            $display("[TB] FAIL single_state: valid=%h count=%0d, required 00000020/1", slot_valid, count);
        end
    endtask

    task automatic test_overwrite();
        exp_t e;
        drive_write(5'd5, 32'h1);
        void'(sb.pop_front());
        drive_write(5'd5, 32'h2);
        e = sb.pop_front();
        vectors++;
        if (d_o[191:160] !== e.data || count !== 6'd1 || slot_valid !== 32'h20) begin
            miscompares++;
            $display("[TB] FAIL overwrite: slot5=%h count=%0d valid=%h, required %h/1/00000020",
                     d_o[191:160], count, slot_valid, e.data);
        end
    endtask

    task automatic test_fill();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            drive_write(5'(i), DW'(i));
            e = sb.pop_front();
            vectors++;
            if (d_o[int'(e.sel)*DW +: DW] !== e.data || slot_valid !== e.valid ||
                count !== e.cnt || full !== e.full) begin
                miscompares++;
                $display("[TB] FAIL fill[%0d]: data=%h valid=%h count=%0d full=%b, required %h/%h/%0d/%b",
                         i, d_o[int'(e.sel)*DW +: DW], slot_valid, count, full, e.data, e.valid, e.cnt, e.full);
            end
        end
        vectors++;
        if (full !== 1'b1 || count !== 6'd32 || d_o !== model_bus()) begin
            miscompares++;
            $display("[TB] FAIL fill_full: full=%b count=%0d bus_ok=%b, required 1/32/1", full, count, d_o === model_bus());
        end
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_ready: got %b, required 1", wr_ready);
        end
        drive_write(5'd0, 32'hFF);
        e = sb.pop_front();
        vectors++;
        if (d_o[31:0] !== e.data || count !== 6'd32 || full !== 1'b1 || d_o !== model_bus()) begin
            miscompares++;
            $display("[TB] FAIL full_overwrite: slot0=%h count=%0d full=%b, required 000000ff/32/1", d_o[31:0], count, full);
        end
    endtask

    task automatic test_random();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive_write(5'($urandom_range(0, 31)), DW'($urandom));
            e = sb.pop_front();
            vectors++;
            if (d_o !== model_bus() || slot_valid !== e.valid || count !== e.cnt || full !== e.full) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: sel=%0d valid=%h count=%0d, required %h/%0d",
                         i, e.sel, slot_valid, count, e.valid, e.cnt);
            end
        end
    endtask

`ifdef DEMUX_CLEAR_EN
    task automatic test_clear_full();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            drive_write(5'(i), DW'(32'hA000 + i));
            void'(sb.pop_front());
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (wr_ready !== 1'b0 || count !== 6'(32 - i)) begin
                miscompares++;
                $display("[TB] FAIL clear_step[%0d]: wr_ready=%b count=%0d, required 0/%0d", i, wr_ready, count, 32 - i);
            end
            clr = (i >= 18 && i <= 22);
            @(posedge clk); #1;
        end
        clr = 1'b0;
        vectors++;
        if (wr_ready !== 1'b1 || count !== 6'd0 || full !== 1'b0 || d_o !== '0 || slot_valid !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL clear_done: wr_ready=%b count=%0d valid=%h, required 1/0/00000000",
                     wr_ready, count, slot_valid);
        end
    endtask

    task automatic test_clear_write_reset();
        apply_reset();
        for (int i = 20; i < 26; i++) begin
            drive_write(5'(i), DW'(32'hC0DE0000 + i));
            void'(sb.pop_front());
        end
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_sel   = 5'd3;
        wr_data  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        clr      = 1'b0;
        wr_valid = 1'b0;
        vectors++;
        if (d_o[127:96] !== 32'hA5A5A5A5 || count !== 6'd7 || wr_ready !== 1'b0 || slot_valid !== 32'h03F0_0008) begin
            miscompares++;
            $display("[TB] FAIL clr_write: slot3=%h count=%0d ready=%b valid=%h, required a5a5a5a5/7/0/03f00008",
                     d_o[127:96], count, wr_ready, slot_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (d_o[127:96] !== 32'hA5A5A5A5 || count !== 6'd7) begin
            miscompares++;
            $display("[TB] FAIL clr_before3: slot3=%h count=%0d, required a5a5a5a5/7", d_o[127:96], count);
        end
        @(posedge clk); #1;
        vectors++;
        if (d_o[127:96] !== 32'h0 || count !== 6'd6 || slot_valid !== 32'h03F0_0000) begin
            miscompares++;
            $display("[TB] FAIL clr_at3: slot3=%h count=%0d valid=%h, required 0/6/03f00000", d_o[127:96], count, slot_valid);
        end
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (wr_ready !== 1'b1 || d_o !== '0 || slot_valid !== 32'h0 || count !== 6'd0 || full !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_reset: ready=%b count=%0d valid=%h, required 1/0/00000000", wr_ready, count, slot_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clr_reset_hold: ready=%b, required 1", wr_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_overwrite();
        test_fill();
        test_random();
`ifdef DEMUX_CLEAR_EN
        test_clear_full();
        test_clear_write_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_store.md
DEMUX_STORE -- requirements
Module: demux_store

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of one slot word.
REQ-002 SHALL have parameter SIZE, default DATA_SIZE*32: width of the packed slot bus.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port wr_valid  input  1  write request.
REQ-006 SHALL have port wr_ready  output  1  write can be accepted this cycle.
REQ-007 SHALL have port wr_sel  input  5  target slot index, 0..31.
REQ-008 SHALL have port wr_data  input  DATA_SIZE  word to store.
REQ-009 SHALL have port clr  input  1  clear-all request (present only with DEMUX_CLEAR_EN).
REQ-010 SHALL have port d_o  output  SIZE  packed slots; slot k at bits [DATA_SIZE*(k+1)-1 : DATA_SIZE*k].
REQ-011 SHALL have port slot_valid  output  32  bit k set when slot k holds written data.
REQ-012 SHALL have port count  output  6  number of set slot_valid bits, 0..32.
REQ-013 SHALL have port full  output  1  high when count == 32.

Function
REQ-014 SHALL accept a write in any cycle where wr_valid && wr_ready are both high at the clock edge.
REQ-015 SHALL, on acceptance, load wr_data into slot wr_sel and set slot_valid[wr_sel]; d_o and slot_valid show it the next cycle (latency 1).
REQ-016 SHALL leave all other slots unchanged on a write.
REQ-017 SHALL increment count on a write only when the target slot was invalid; an overwrite of a valid slot leaves count unchanged.
REQ-018 SHALL accept writes while full (overwrite only); full never blocks wr_ready.
REQ-019 SHALL drive d_o, slot_valid, count and full directly from registers (no combinational path from inputs).
REQ-020 SHALL use a two-state FSM: IDLE and CLEAR; wr_ready = (state == IDLE), derived from state only.
REQ-021 SHALL move IDLE -> CLEAR when clr is high at an edge; a write accepted in the same cycle is still performed.
REQ-022 SHALL, in CLEAR, hold a 5-bit clear index starting at 0 and each cycle zero slot[index] data, clear slot_valid[index], and decrement count if that slot was valid.
REQ-023 SHALL move CLEAR -> IDLE after index 31 has been cleared (exactly 32 cycles in CLEAR); count is 0 on exit.
REQ-024 SHALL ignore clr while in CLEAR (no restart).

Reset
REQ-025 SHALL, on rst, set state IDLE, clear index 0, all slot data 0, slot_valid 0, count 0, full 0; wr_ready is 1 the cycle after reset.
REQ-026 SHALL give rst priority over writes and clear, including mid-CLEAR (clear aborts, everything zeroed).

Configuration
REQ-027 SHALL, with DEMUX_CLEAR_EN defined, include clr port, CLEAR state and clear index as in REQ-020..024.
REQ-028 SHALL, without DEMUX_CLEAR_EN, omit clr, have no CLEAR state, tie wr_ready to 1, and otherwise behave identically.

Verification
REQ-029 SHALL cover: reset, write sel=5 data=0xDEADBEEF -> next cycle d_o[191:160]=0xDEADBEEF, slot_valid=0x20, count=1.
REQ-030 SHALL cover: write sel=5 twice (0x1 then 0x2) -> slot 5 = 0x2, count stays 1.
REQ-031 SHALL cover: write all 32 slots with data=index -> full=1, count=32; further write sel=0 data=0xFF accepted, count=32.
REQ-032 SHALL cover (DEMUX_CLEAR_EN): clr with 32 valid slots -> wr_ready=0 for 32 cycles, count falls 32..0, afterwards d_o=0, slot_valid=0.
REQ-033 SHALL cover (DEMUX_CLEAR_EN): clr and write sel=3 same cycle -> write lands, then cleared at clear cycle 3; rst asserted in clear cycle 10 -> next cycle state IDLE, all outputs zero.
